// File: rtl/uart_host_driver.sv
`default_nettype none
// ============================================================================
// uart_host_driver : configures a UART and moves TX/RX bytes over its 3-phase
//                    CPU bus (P0 address, P1 strobe, P2 release). Rev 1.0
// ============================================================================

module uart_host_driver #(
   parameter int POLL_GAP = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] cfg_baud,
   input  logic [7:0] cfg_intmask,
   input  logic       init_start,
   output logic       init_done,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic [1:0] rx_err,
   output logic [1:0] ADDR,
   output logic       NCS,
   output logic       NO,
   output logic       NW,
   output logic [7:0] DATA_OUT,
   output logic       DATA_OE,
   input  logic [7:0] DATA_IN,
   input  logic       NINT
);

   localparam logic [3:0] S_UNCFG    = 4'd0;
   localparam logic [3:0] S_CFG_BAUD = 4'd1;
   localparam logic [3:0] S_CFG_MASK = 4'd2;
   localparam logic [3:0] S_CFG_EN   = 4'd3;
   localparam logic [3:0] S_READY    = 4'd4;
   localparam logic [3:0] S_TX_POLL  = 4'd5;
   localparam logic [3:0] S_TX_WAIT  = 4'd6;
   localparam logic [3:0] S_TX_DATA  = 4'd7;
   localparam logic [3:0] S_TX_GO    = 4'd8;
   localparam logic [3:0] S_RX_STAT  = 4'd9;
   localparam logic [3:0] S_RX_DATA  = 4'd10;
   localparam logic [3:0] S_RX_ACK   = 4'd11;

   localparam int              GAP_W    = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

   logic [3:0]       state_q, state_d;
   logic [1:0]       phase_q, phase_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [7:0]       byte_q, byte_d;
   logic [7:0]       baud_q, baud_d;
   logic [7:0]       mask_q, mask_d;
   logic [7:0]       rd_q, rd_d;
   logic [1:0]       err_q, err_d;
   logic             init_done_q, init_done_d;
   logic             rx_valid_q, rx_valid_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic [1:0]       rx_err_q, rx_err_d;

   logic             acc;
   logic             is_wr;
   logic [1:0]       bus_addr;
   logic [7:0]       bus_wdata;
   logic             last_phase;

   // Each access state maps to one fixed register access.
   always_comb begin
      acc       = 1'b1;
      is_wr     = 1'b1;
      bus_addr  = 2'd0;
      bus_wdata = 8'h00;
      case (state_q)
         S_CFG_BAUD: begin bus_addr = 2'd3; bus_wdata = baud_q; end
         S_CFG_MASK: begin bus_addr = 2'd1; bus_wdata = mask_q; end
         S_CFG_EN:   bus_wdata = 8'h01;
         S_TX_POLL:  is_wr = 1'b0;
         S_TX_DATA:  begin bus_addr = 2'd2; bus_wdata = byte_q; end
         S_TX_GO:    bus_wdata = 8'h03;
         S_RX_STAT:  is_wr = 1'b0;
         S_RX_DATA:  begin is_wr = 1'b0; bus_addr = 2'd2; end
         S_RX_ACK:   bus_wdata = 8'h01;
         default:    begin acc = 1'b0; is_wr = 1'b0; end
      endcase
   end

   assign last_phase = (phase_q == 2'd2);

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      gap_d       = gap_q;
      byte_d      = byte_q;
      baud_d      = baud_q;
      mask_d      = mask_q;
      rd_d        = rd_q;
      err_d       = err_q;
      init_done_d = init_done_q;
      rx_valid_d  = 1'b0;
      rx_data_d   = rx_data_q;
      rx_err_d    = rx_err_q;

      if (acc) begin
         phase_d = last_phase ? 2'd0 : phase_q + 2'd1;
      end
      // Read data is captured on the edge that closes P1.
      if (acc && !is_wr && phase_q == 2'd1) begin
         rd_d = DATA_IN;
      end

      case (state_q)
         S_UNCFG: begin
            if (init_start) begin
               baud_d  = cfg_baud;
               mask_d  = cfg_intmask;
               state_d = S_CFG_BAUD;
            end
         end
         S_CFG_BAUD: if (last_phase) state_d = S_CFG_MASK;
         S_CFG_MASK: if (last_phase) state_d = S_CFG_EN;
         S_CFG_EN: begin
            if (last_phase) begin
               state_d     = S_READY;
               init_done_d = 1'b1;
            end
         end
         S_READY: begin
            if (!NINT) begin
               state_d = S_RX_STAT;
            end else if (tx_valid) begin
               byte_d  = tx_data;
               state_d = S_TX_POLL;
            end
         end
         S_TX_POLL: begin
            if (last_phase) begin
               gap_d = '0;
               if (!rd_q[2])          state_d = S_TX_DATA;
               else if (POLL_GAP == 0) state_d = S_TX_POLL;
               else                    state_d = S_TX_WAIT;
            end
         end
         S_TX_WAIT: begin
            if (gap_q == GAP_LAST) state_d = S_TX_POLL;
            else                   gap_d   = gap_q + 1'b1;
         end
         S_TX_DATA: if (last_phase) state_d = S_TX_GO;
         S_TX_GO:   if (last_phase) state_d = S_READY;
         S_RX_STAT: begin
            if (last_phase) begin
               err_d   = {rd_q[7], rd_q[5]};
               state_d = rd_q[4] ? S_RX_DATA : S_RX_ACK;
            end
         end
         S_RX_DATA: begin
            if (last_phase) begin
               rx_valid_d = 1'b1;
               rx_data_d  = rd_q;
               rx_err_d   = err_q;
               state_d    = S_RX_ACK;
            end
         end
         S_RX_ACK:  if (last_phase) state_d = S_READY;
         default:   state_d = S_UNCFG;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= S_UNCFG;
         phase_q     <= 2'd0;
         gap_q       <= '0;
         byte_q      <= 8'h00;
         baud_q      <= 8'h00;
         mask_q      <= 8'h00;
         rd_q        <= 8'h00;
         err_q       <= 2'b00;
         init_done_q <= 1'b0;
         rx_valid_q  <= 1'b0;
         rx_data_q   <= 8'h00;
         rx_err_q    <= 2'b00;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         gap_q       <= gap_d;
         byte_q      <= byte_d;
         baud_q      <= baud_d;
         mask_q      <= mask_d;
         rd_q        <= rd_d;
         err_q       <= err_d;
         init_done_q <= init_done_d;
         rx_valid_q  <= rx_valid_d;
         rx_data_q   <= rx_data_d;
         rx_err_q    <= rx_err_d;
      end
   end

   assign NCS       = ~acc;
   assign NW        = ~(acc & is_wr & (phase_q == 2'd1));
   assign NO        = ~(acc & ~is_wr & (phase_q == 2'd1));
   assign DATA_OE   = acc & is_wr;
   assign ADDR      = bus_addr;
   assign DATA_OUT  = bus_wdata;
   assign tx_ready  = (state_q == S_READY) & NINT;
   assign init_done = init_done_q;
   assign rx_valid  = rx_valid_q;
   assign rx_data   = rx_data_q;
   assign rx_err    = rx_err_q;

endmodule

`default_nettype wire
